// File: rtl/reg_window_ctrl.sv
// rtl/reg_window_ctrl.sv - call/return window sequencer with spill/fill to a memory stack
module reg_window_ctrl #(
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] STACK_BASE = 16'h0100,
    parameter int                STACK_WIN  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_call,
    input  logic              i_ret,
    output logic [1:0]        o_wind,
    output logic              o_stall,
    output logic              o_win_err,
    output logic              o_rf_override,
    output logic [2:0]        o_rf_addr,
    input  logic [DATA_W-1:0] i_rf_rdata,
    output logic              o_rf_we,
    output logic [DATA_W-1:0] o_rf_wdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ack
);

    localparam logic [ADDR_W-1:0] STACK_TOP = STACK_BASE + ADDR_W'(2 * STACK_WIN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPILL_RD,
        S_SPILL_WR,
        S_FILL_REQ,
        S_FILL_WR
    } state_t;

    state_t              r_state;
    logic [1:0]          r_cwp;
    logic [2:0]          r_resident;
    logic [ADDR_W-1:0]   r_sp;
    logic                r_idx;
    logic [DATA_W-1:0]   r_data;
    logic                r_err;

    logic                w_idle;
    logic                w_call_only;
    logic                w_ret_only;
    logic                w_room;
    logic                w_has_data;
    logic                w_start_spill;
    logic                w_start_fill;
    logic [1:0]          w_victim;
    logic [1:0]          w_target;

    // The oldest resident window sits just ahead of cwp; the one to restore sits just behind.
    assign w_victim      = r_cwp + 2'd1;
    assign w_target      = r_cwp - 2'd1;
    assign w_idle        = (r_state == S_IDLE);
    assign w_call_only   = i_call & ~i_ret;
    assign w_ret_only    = i_ret & ~i_call;
    assign w_room        = (r_sp < STACK_TOP);
    assign w_has_data    = (r_sp > STACK_BASE);
    assign w_start_spill = w_idle & w_call_only & (r_resident == 3'd4) & w_room;
    assign w_start_fill  = w_idle & w_ret_only & (r_resident == 3'd1) & w_has_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cwp      <= 2'd0;
            r_resident <= 3'd1;
            r_sp       <= STACK_BASE;
            r_idx      <= 1'b0;
            r_data     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_call && i_ret) begin
                        r_err <= 1'b1;
                    end else if (i_call) begin
                        if (r_resident != 3'd4) begin
                            r_cwp      <= r_cwp + 2'd1;
                            r_resident <= r_resident + 3'd1;
                        end else if (w_room) begin
                            r_state <= S_SPILL_RD;
                            r_idx   <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else if (i_ret) begin
                        if (r_resident > 3'd1) begin
                            r_cwp      <= r_cwp - 2'd1;
                            r_resident <= r_resident - 3'd1;
                        end else if (w_has_data) begin
                            r_state <= S_FILL_REQ;
                            r_idx   <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_SPILL_RD: begin
                    r_data  <= i_rf_rdata;
                    r_state <= S_SPILL_WR;
                end
                S_SPILL_WR: begin
                    if (i_mem_ack) begin
                        r_sp <= r_sp + ADDR_W'(1);
                        if (!r_idx) begin
                            r_idx   <= 1'b1;
                            r_state <= S_SPILL_RD;
                        end else begin
                            r_state <= S_IDLE;
                            r_cwp   <= r_cwp + 2'd1;
                        end
                    end
                end
                S_FILL_REQ: begin
                    if (i_mem_ack) begin
                        r_data  <= i_mem_rdata;
                        r_sp    <= r_sp - ADDR_W'(1);
                        r_state <= S_FILL_WR;
                    end
                end
                S_FILL_WR: begin
                    if (r_idx) begin
                        r_idx   <= 1'b0;
                        r_state <= S_FILL_REQ;
                    end else begin
                        r_state <= S_IDLE;
                        r_cwp   <= w_target;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_wind        = r_cwp;
    assign o_win_err     = r_err;
    assign o_stall       = ~w_idle | w_start_spill | w_start_fill;
    assign o_rf_override = ~w_idle;

    always_comb begin
        o_rf_addr   = 3'd0;
        o_rf_we     = 1'b0;
        o_rf_wdata  = '0;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        case (r_state)
            S_SPILL_RD: o_rf_addr = {w_victim, r_idx};
            S_SPILL_WR: begin
                o_mem_req   = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = r_sp;
                o_mem_wdata = r_data;
            end
            S_FILL_REQ: begin
                o_mem_req  = 1'b1;
                o_mem_addr = r_sp - ADDR_W'(1);
            end
            S_FILL_WR: begin
                o_rf_we    = 1'b1;
                o_rf_addr  = {w_target, r_idx};
                o_rf_wdata = r_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_window_ctrl.sv
// tb/tb_reg_window_ctrl.sv - self-checking bench for reg_window_ctrl
module tb_reg_window_ctrl;

    localparam logic [15:0] BASE = 16'h0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [1:0]  wind;
    logic        stall, win_err, rf_override, rf_we, mem_req, mem_we, mem_ack;
    logic [2:0]  rf_addr;
    logic [15:0] rf_rdata, rf_wdata, mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    reg_window_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_call(call), .i_ret(ret),
        .o_wind(wind), .o_stall(stall), .o_win_err(win_err),
        .o_rf_override(rf_override), .o_rf_addr(rf_addr), .i_rf_rdata(rf_rdata),
        .o_rf_we(rf_we), .o_rf_wdata(rf_wdata),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack)
    );

    // Environment: register file, stack memory with programmable ack latency, activity logs
    logic [15:0] rf [8];
    logic [15:0] rf_img [8];
    logic        rf_ld = 1'b0;
    logic [15:0] mem [32];
    int          ack_delay = 0;
    int          ack_cnt;
    int          req_cycles;
    logic [15:0] mlog_addr[$], mlog_data[$];
    logic        mlog_we[$];
    logic [2:0]  rlog_addr[$], rdlog[$];
    logic [15:0] rlog_data[$];

    assign rf_rdata  = rf[rf_addr];
    assign mem_rdata = mem[mem_addr[4:0]];
    assign mem_ack   = mem_req && (ack_cnt == ack_delay);

    always @(posedge clk) begin
        if (rst || !mem_req || mem_ack) ack_cnt <= 0;
        else ack_cnt <= ack_cnt + 1;
        if (rst) req_cycles <= 0;
        else if (mem_req) req_cycles <= req_cycles + 1;
        if (!rst && mem_req && mem_ack) begin
            if (mem_we) mem[mem_addr[4:0]] <= mem_wdata;
            mlog_we.push_back(mem_we);
            mlog_addr.push_back(mem_addr);
            mlog_data.push_back(mem_we ? mem_wdata : mem_rdata);
        end
        if (!rst && rf_override && !mem_req && !rf_we) rdlog.push_back(rf_addr);
        if (!rst && rf_we) begin
            rf[rf_addr] <= rf_wdata;
            rlog_addr.push_back(rf_addr);
            rlog_data.push_back(rf_wdata);
        end else if (rf_ld) begin
            for (int i = 0; i < 8; i++) rf[i] <= rf_img[i];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: window pointer, resident count and the spill stack as a LIFO of words
    int          m_cwp, m_res;
    logic [15:0] m_stack[$];

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; call = 1'b0; ret = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_cwp = 0; m_res = 1; m_stack.delete();
    endtask

    task automatic load_rf(input bit rnd, input logic [15:0] r0, input logic [15:0] r1);
        @(negedge clk);
        for (int i = 0; i < 8; i++) rf_img[i] = 16'($urandom);
        if (!rnd) begin rf_img[0] = r0; rf_img[1] = r1; end
        rf_ld = 1'b1;
        @(posedge clk); #1;
        rf_ld = 1'b0;
    endtask

    task automatic run_op(input bit c, input bit r, input int dly);
        int          kind, win, cnt, mb, rb, db, qb, sz;
        bit          e_err, bad_stab, bad_stall;
        logic [15:0] e_addr[2], e_data[2];
        logic        p_req, p_ack, p_we;
        logic [15:0] p_addr, p_wdata;
        kind = 0; e_err = 0; win = 0;
        sz = m_stack.size();
        if (c && r) e_err = 1;
        else if (c) begin
            if (m_res < 4) begin m_cwp = (m_cwp + 1) % 4; m_res++; end
            else if (sz < 16) begin
                kind = 1; win = (m_cwp + 1) % 4;
                e_addr[0] = BASE + 16'(sz);     e_data[0] = rf[2 * win];
                e_addr[1] = BASE + 16'(sz + 1); e_data[1] = rf[2 * win + 1];
                m_stack.push_back(e_data[0]); m_stack.push_back(e_data[1]);
                m_cwp = (m_cwp + 1) % 4;
            end else e_err = 1;
        end else if (r) begin
            if (m_res > 1) begin m_cwp = (m_cwp + 3) % 4; m_res--; end
            else if (sz > 0) begin
                kind = 2; win = (m_cwp + 3) % 4;
                e_addr[0] = BASE + 16'(sz - 1); e_data[0] = m_stack.pop_back();
                e_addr[1] = BASE + 16'(sz - 2); e_data[1] = m_stack.pop_back();
                m_cwp = win;
            end else e_err = 1;
        end
        ack_delay = dly;
        mb = mlog_addr.size(); rb = rlog_addr.size(); db = rdlog.size(); qb = req_cycles;
        @(negedge clk);
        call = c; ret = r;
        #1 chk("stall on request", 32'(stall), 32'(kind != 0));
        @(posedge clk); #1;
        call = 1'b0; ret = 1'b0;
        chk("win_err", 32'(win_err), 32'(e_err));
        cnt = 0; bad_stab = 0; bad_stall = 0; p_req = 0; p_ack = 0;
        p_we = 0; p_addr = '0; p_wdata = '0;
        while (rf_override && cnt < 100) begin
            cnt++;
            if (!stall) bad_stall = 1;
            if (mem_req && p_req && !p_ack &&
                (mem_addr !== p_addr || mem_wdata !== p_wdata || mem_we !== p_we)) bad_stab = 1;
            p_req = mem_req; p_ack = mem_ack; p_addr = mem_addr; p_wdata = mem_wdata; p_we = mem_we;
            @(posedge clk); #1;
        end
        chk("busy cycles", 32'(cnt), (kind != 0) ? 32'(4 + 2 * dly) : 32'd0);
        chk("wind", 32'(wind), 32'(m_cwp));
        if (kind == 0) begin
            chk("no mem_req", 32'(req_cycles - qb), 32'd0);
        end else begin
            chk("stall held while busy", 32'(bad_stall), 32'd0);
            chk("mem held until ack", 32'(bad_stab), 32'd0);
            chk("mem op count", 32'(mlog_addr.size() - mb), 32'd2);
            for (int k = 0; k < 2; k++) begin
                chk("mem addr", 32'(mlog_addr[mb + k]), 32'(e_addr[k]));
                chk("mem data", 32'(mlog_data[mb + k]), 32'(e_data[k]));
                chk("mem we", 32'(mlog_we[mb + k]), 32'(kind == 1));
            end
            if (kind == 1) begin
                chk("spill rf reads", 32'(rdlog.size() - db), 32'd2);
                chk("spill rf addr0", 32'(rdlog[db]), 32'(2 * win));
                chk("spill rf addr1", 32'(rdlog[db + 1]), 32'(2 * win + 1));
            end else begin
                chk("fill rf writes", 32'(rlog_addr.size() - rb), 32'd2);
                chk("fill rf addr0", 32'(rlog_addr[rb]), 32'(2 * win + 1));
                chk("fill rf data0", 32'(rlog_data[rb]), 32'(e_data[0]));
                chk("fill rf addr1", 32'(rlog_addr[rb + 1]), 32'(2 * win));
                chk("fill rf data1", 32'(rlog_data[rb + 1]), 32'(e_data[1]));
            end
        end
    endtask

    typedef struct {
        bit         c;
        bit         r;
        bit         e_stall;
        bit         e_err;
        logic [1:0] e_wind;
    } vec_t;

    vec_t vecs[8];
    int   b;

    initial begin
        vecs[0] = '{c: 0, r: 1, e_stall: 0, e_err: 1, e_wind: 2'd0};
        vecs[1] = '{c: 1, r: 1, e_stall: 0, e_err: 1, e_wind: 2'd0};
        vecs[2] = '{c: 1, r: 0, e_stall: 0, e_err: 0, e_wind: 2'd1};
        vecs[3] = '{c: 1, r: 0, e_stall: 0, e_err: 0, e_wind: 2'd2};
        vecs[4] = '{c: 1, r: 0, e_stall: 0, e_err: 0, e_wind: 2'd3};
        vecs[5] = '{c: 1, r: 1, e_stall: 0, e_err: 1, e_wind: 2'd3};
        vecs[6] = '{c: 0, r: 1, e_stall: 0, e_err: 0, e_wind: 2'd2};
        vecs[7] = '{c: 1, r: 0, e_stall: 0, e_err: 0, e_wind: 2'd3};

        for (int i = 0; i < 8; i++) begin rf_img[i] = '0; rf[i] = '0; end
        for (int i = 0; i < 32; i++) mem[i] = '0;
        do_reset();
        chk("reset wind", 32'(wind), 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset win_err", 32'(win_err), 32'd0);
        chk("reset rf_override", 32'(rf_override), 32'd0);
        chk("reset mem_req", 32'(mem_req), 32'd0);
        chk("reset rf_we", 32'(rf_we), 32'd0);

        // Table: single-cycle operations that never touch the stack
        b = req_cycles;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            call = vecs[i].c; ret = vecs[i].r;
            #1 chk($sformatf("vec%0d stall", i), 32'(stall), 32'(vecs[i].e_stall));
            @(posedge clk); #1;
            call = 1'b0; ret = 1'b0;
            chk($sformatf("vec%0d win_err", i), 32'(win_err), 32'(vecs[i].e_err));
            chk($sformatf("vec%0d wind", i), 32'(wind), 32'(vecs[i].e_wind));
        end
        chk("table no mem_req", 32'(req_cycles - b), 32'd0);

        // Overflow with zero-wait ack, then unwind through an underflow fill
        do_reset();
        for (int i = 0; i < 3; i++) run_op(1, 0, 0);
        load_rf(0, 16'hAAAA, 16'h5555);
        b = mlog_addr.size();
        run_op(1, 0, 0);
        chk("A spill addr0", 32'(mlog_addr[b]), 32'h0100);
        chk("A spill data0", 32'(mlog_data[b]), 32'hAAAA);
        chk("A spill addr1", 32'(mlog_addr[b + 1]), 32'h0101);
        chk("A spill data1", 32'(mlog_data[b + 1]), 32'h5555);
        chk("A wind after spill", 32'(wind), 32'd0);
        for (int i = 0; i < 3; i++) begin
            run_op(0, 1, 0);
            chk("A free ret wind", 32'(wind), 32'(3 - i));
        end
        load_rf(0, 16'h0000, 16'h0000);
        b = mlog_addr.size();
        run_op(0, 1, 0);
        chk("A fill addr0", 32'(mlog_addr[b]), 32'h0101);
        chk("A fill addr1", 32'(mlog_addr[b + 1]), 32'h0100);
        chk("A rf1 restored", 32'(rf[1]), 32'h5555);
        chk("A rf0 restored", 32'(rf[0]), 32'hAAAA);
        chk("A wind after fill", 32'(wind), 32'd0);
        run_op(0, 1, 0);

        // Overflow with 3-cycle ack latency
        do_reset();
        for (int i = 0; i < 3; i++) run_op(1, 0, 0);
        load_rf(1, 16'h0, 16'h0);
        run_op(1, 0, 3);

        // Reset in the middle of a spill write
        do_reset();
        for (int i = 0; i < 3; i++) run_op(1, 0, 0);
        ack_delay = 5;
        @(negedge clk); call = 1'b1;
        @(negedge clk); call = 1'b0;
        @(posedge clk); #1;
        chk("C in SPILL_WR", 32'(mem_req), 32'd1);
        chk("C first spill addr", 32'(mem_addr), 32'h0100);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("C rst mem_req", 32'(mem_req), 32'd0);
        chk("C rst rf_override", 32'(rf_override), 32'd0);
        chk("C rst wind", 32'(wind), 32'd0);
        chk("C rst stall", 32'(stall), 32'd0);
        rst = 1'b0;
        m_cwp = 0; m_res = 1; m_stack.delete();
        run_op(0, 1, 0);
        for (int i = 0; i < 4; i++) run_op(1, 0, 1);

        // Randomized operations against the model, including stack-full conditions
        do_reset();
        for (int n = 0; n < 250; n++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (n % 5 == 0) load_rf(1, 16'h0, 16'h0);
            if (n < 125) run_op(sel < 60, sel >= 90, int'($urandom_range(0, 2)));
            else run_op(sel < 35 || sel >= 90, sel >= 35, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_window_ctrl.md
Name: reg_window_ctrl

Overview:
Call/return sequencer for the 4-window, 8x16-bit windowed register file. It tracks the current window pointer (wind) and how many windows are resident. On window overflow it spills the oldest window's two private registers to a memory stack. On underflow it fills them back. During spill/fill it takes over the register file's physical port and stalls the pipeline.

Parameters:
DATA_W, 16, register/memory data width
ADDR_W, 16, memory address width
STACK_BASE, 16'h0100, lowest spill-stack address (stack grows upward)
STACK_WIN, 8, max spilled windows (stack holds 2*STACK_WIN words)

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  synchronous, active-high reset
call  in  1  pipeline requests window advance (1-cycle pulse)
ret  in  1  pipeline requests window retreat (1-cycle pulse)
wind  out  2  current window pointer to register file
stall  out  1  pipeline hold
win_err  out  1  1-cycle error pulse
rf_override  out  1  register file uses rf_addr as physical index, bypasses window map
rf_addr  out  3  physical register index
rf_rdata  in  DATA_W  physical read data (combinational from rf_addr)
rf_we  out  1  physical write strobe
rf_wdata  out  DATA_W  physical write data
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1=write (spill), 0=read (fill)
mem_addr  out  ADDR_W  word address
mem_wdata  out  DATA_W  spill data
mem_rdata  in  DATA_W  fill data, valid with mem_ack
mem_ack  in  1  1-cycle completion

Behaviour:
- Window w owns physical regs 2w and 2w+1. The pipeline's logical access path is untouched.
- Internal state: cwp (2b), resident (0..4), sp (ADDR_W), idx (1b), data latch, FSM {IDLE, SPILL_RD, SPILL_WR, FILL_REQ, FILL_WR}.
- Reset: cwp=0, wind=0, resident=1, sp=STACK_BASE, state IDLE. All other outputs 0. Reset mid spill/fill aborts immediately, and any stack contents are discarded.
- wind = cwp (registered).
- stall = (state!=IDLE) | (IDLE & a call/ret that starts spill/fill). It is combinational.
- rf_override = (state!=IDLE).
- call/ret are sampled only in IDLE and ignored otherwise. call&ret together: no action, win_err=1.
- call, resident<4: next cycle cwp=cwp+1 mod 4, resident+1. No stall.
- call, resident==4, sp<STACK_BASE+2*STACK_WIN:
  - Victim is v=cwp+1 mod 4 (the oldest window). Enter SPILL_RD with idx=0.
  - SPILL_RD (1 cycle): rf_addr=2v+idx, latch rf_rdata, go to SPILL_WR.
  - SPILL_WR: mem_req=1, mem_we=1, mem_addr=sp, mem_wdata=latch, all held stable until mem_ack.
  - On mem_ack: sp+1. If idx==0, set idx=1 and return to SPILL_RD. Otherwise go to IDLE with cwp=cwp+1 mod 4 and resident unchanged (4).
  - Minimum overflow cost with zero-wait ack is 4 stall cycles.
- call, resident==4, stack full: win_err=1, no state change.
- ret, resident>1: cwp=cwp-1 mod 4, resident-1. No stall.
- ret, resident==1, sp>STACK_BASE:
  - Target is t=cwp-1 mod 4. Enter FILL_REQ with idx=1 (LIFO order).
  - FILL_REQ: mem_req=1, mem_we=0, mem_addr=sp-1, held until mem_ack. On ack, latch mem_rdata, sp-1, go to FILL_WR.
  - FILL_WR (1 cycle): rf_we=1, rf_addr=2t+idx, rf_wdata=latch. If idx==1, set idx=0 and return to FILL_REQ. Otherwise go to IDLE with cwp=t and resident unchanged (1).
- ret, resident==1, sp==STACK_BASE: win_err=1, no state change.
- mem_ack outside SPILL_WR/FILL_REQ is ignored.
- sp arithmetic is unsigned ADDR_W. Bounds are checked before starting, so sp never wraps.

Test Plan:
- Reset, then 3 calls with no stall -> wind 0→1→2→3, resident=4, mem_req never asserted.
- 4th call with rf regs 0,1=16'hAAAA,16'h5555 and zero-wait ack -> mem writes 16'h0100=AAAA then 16'h0101=5555, rf_addr 0 then 1, stall exactly 4 cycles, wind=0, sp=16'h0102.
- 4 rets after the above -> 3 free decrements (wind 3,2,1). 4th ret fills: mem read 16'h0101→rf phys 7? No: t=0, so reads 16'h0101→phys 1 then 16'h0100→phys 0, rf_we twice, wind=0, sp=16'h0100.
- ret at reset state -> win_err single pulse, wind=0, stall=0, no mem_req.
- Spill with mem_ack delayed 3 cycles -> mem_addr/mem_wdata/mem_req held stable throughout, stall extends to 10 cycles.
- rst asserted during SPILL_WR -> next cycle state IDLE, mem_req=0, rf_override=0, wind=0, sp=STACK_BASE. Also, call&ret in the same cycle -> win_err=1, wind unchanged.
